// File: rtl/rv32i_decode_exec_unit.sv
// rv32i_decode_exec_unit: combinational RV32I decode, control generation and execute
// (immediate build, ALU, branch compare) for the single-cycle core.
module rv32i_decode_exec_unit #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       insn_i,
    input  logic [AWIDTH-1:0] pc_i,
    input  logic [DWIDTH-1:0] rs1data_i,
    input  logic [DWIDTH-1:0] rs2data_i,
    output logic [AWIDTH-1:0] pc_o,
    output logic [31:0]       insn_o,
    output logic [6:0]        opcode_o,
    output logic [4:0]        rd_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [2:0]        funct3_o,
    output logic [6:0]        funct7_o,
    output logic [4:0]        shamt_o,
    output logic [DWIDTH-1:0] imm_o,
    output logic              pcsel_o,
    output logic              immsel_o,
    output logic              regwren_o,
    output logic              rs1sel_o,
    output logic              rs2sel_o,
    output logic              memren_o,
    output logic              memwren_o,
    output logic [1:0]        wbsel_o,
    output logic [3:0]        alusel_o,
    output logic [DWIDTH-1:0] res_o,
    output logic              brtaken_o
);
    localparam logic [6:0] OP_R     = 7'h33;
    localparam logic [6:0] OP_IMM   = 7'h13;
    localparam logic [6:0] OP_LOAD  = 7'h03;
    localparam logic [6:0] OP_STORE = 7'h23;
    localparam logic [6:0] OP_BR    = 7'h63;
    localparam logic [6:0] OP_JAL   = 7'h6F;
    localparam logic [6:0] OP_JALR  = 7'h67;
    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_AUIPC = 7'h17;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic              alt;
    logic [31:0]       imm32;
    logic [3:0]        op_alu;
    logic [DWIDTH-1:0] a, b, alu;
    logic [4:0]        sh;
    logic              valid, cmp;
    logic              unused_ok;

    assign unused_ok = &{1'b0, clk, rst};

    assign opcode   = insn_i[6:0];
    assign funct3   = insn_i[14:12];
    assign alt      = insn_i[31:25] == 7'h20;
    assign pc_o     = pc_i;
    assign insn_o   = insn_i;
    assign opcode_o = opcode;
    assign rd_o     = insn_i[11:7];
    assign rs1_o    = insn_i[19:15];
    assign rs2_o    = insn_i[24:20];
    assign funct3_o = funct3;
    assign funct7_o = insn_i[31:25];
    assign shamt_o  = insn_i[24:20];

    always_comb begin
        imm32 = 32'h0;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR: imm32 = {{20{insn_i[31]}}, insn_i[31:20]};
            OP_STORE:                 imm32 = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
            OP_BR:                    imm32 = {{20{insn_i[31]}}, insn_i[7], insn_i[30:25], insn_i[11:8], 1'b0};
            OP_LUI, OP_AUIPC:         imm32 = {insn_i[31:12], 12'h0};
            OP_JAL:                   imm32 = {{12{insn_i[31]}}, insn_i[19:12], insn_i[20], insn_i[30:21], 1'b0};
            default:                  imm32 = 32'h0;
        endcase
    end

    assign imm_o = DWIDTH'($signed(imm32));

    // Shared R/I-ALU op table; SUB only exists for the register form
    always_comb begin
        case (funct3)
            3'd0:    op_alu = (alt && opcode == OP_R) ? ALU_SUB : ALU_ADD;
            3'd1:    op_alu = ALU_SLL;
            3'd2:    op_alu = ALU_SLT;
            3'd3:    op_alu = ALU_SLTU;
            3'd4:    op_alu = ALU_XOR;
            3'd5:    op_alu = alt ? ALU_SRA : ALU_SRL;
            3'd6:    op_alu = ALU_OR;
            default: op_alu = ALU_AND;
        endcase
    end

    always_comb begin
        pcsel_o   = 1'b0;
        immsel_o  = 1'b0;
        regwren_o = 1'b0;
        rs1sel_o  = 1'b0;
        rs2sel_o  = 1'b0;
        memren_o  = 1'b0;
        memwren_o = 1'b0;
        wbsel_o   = 2'd0;
        alusel_o  = ALU_ADD;
        valid     = 1'b1;
        case (opcode)
            OP_R:     begin regwren_o = 1'b1; alusel_o = op_alu; end
            OP_IMM:   begin regwren_o = 1'b1; immsel_o = 1'b1; rs2sel_o = 1'b1; alusel_o = op_alu; end
            OP_LOAD:  begin regwren_o = 1'b1; immsel_o = 1'b1; rs2sel_o = 1'b1; memren_o = 1'b1; wbsel_o = 2'd1; end
            OP_STORE: begin immsel_o = 1'b1; rs2sel_o = 1'b1; memwren_o = 1'b1; end
            OP_BR:    begin pcsel_o = 1'b1; immsel_o = 1'b1; rs1sel_o = 1'b1; rs2sel_o = 1'b1; end
            OP_JAL:   begin pcsel_o = 1'b1; regwren_o = 1'b1; rs1sel_o = 1'b1; rs2sel_o = 1'b1; wbsel_o = 2'd2; end
            OP_JALR:  begin pcsel_o = 1'b1; regwren_o = 1'b1; rs2sel_o = 1'b1; wbsel_o = 2'd2; end
            OP_LUI:   begin regwren_o = 1'b1; immsel_o = 1'b1; wbsel_o = 2'd3; alusel_o = ALU_PASSB; end
            OP_AUIPC: begin regwren_o = 1'b1; rs1sel_o = 1'b1; rs2sel_o = 1'b1; end
            default:  valid = 1'b0;
        endcase
    end

    // LUI selects the immediate without rs2sel, so either select routes imm to B
    assign a  = rs1sel_o ? DWIDTH'(pc_i) : rs1data_i;
    assign b  = (rs2sel_o || immsel_o) ? imm_o : rs2data_i;
    assign sh = b[4:0];

    always_comb begin
        alu = '0;
        case (alusel_o)
            ALU_ADD:   alu = a + b;
            ALU_SUB:   alu = a - b;
            ALU_SLL:   alu = a << sh;
            ALU_SLT:   alu = DWIDTH'($signed(a) < $signed(b));
            ALU_SLTU:  alu = DWIDTH'(a < b);
            ALU_XOR:   alu = a ^ b;
            ALU_SRL:   alu = a >> sh;
            ALU_SRA:   alu = DWIDTH'($signed(a) >>> sh);
            ALU_OR:    alu = a | b;
            ALU_AND:   alu = a & b;
            ALU_PASSB: alu = b;
            default:   alu = '0;
        endcase
    end

    assign res_o = !valid ? '0 : opcode == OP_JALR ? alu & ~DWIDTH'(1) : alu;

    always_comb begin
        case (funct3)
            3'd0:    cmp = rs1data_i == rs2data_i;
            3'd1:    cmp = rs1data_i != rs2data_i;
            3'd4:    cmp = $signed(rs1data_i) < $signed(rs2data_i);
            3'd5:    cmp = $signed(rs1data_i) >= $signed(rs2data_i);
            3'd6:    cmp = rs1data_i < rs2data_i;
            3'd7:    cmp = rs1data_i >= rs2data_i;
            default: cmp = 1'b0;
        endcase
    end

    assign brtaken_o = opcode == OP_BR ? cmp : (opcode == OP_JAL || opcode == OP_JALR);
endmodule

// File: tb/tb_rv32i_decode_exec_unit.sv
// tb_rv32i_decode_exec_unit: directed vectors with hand-computed expectations
// for the combinational RV32I decode/execute block.
module tb_rv32i_decode_exec_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] insn_i = '0, pc_i = '0, rs1data_i = '0, rs2data_i = '0;
    logic [31:0] pc_o, insn_o, imm_o, res_o;
    logic [6:0]  opcode_o, funct7_o;
    logic [4:0]  rd_o, rs1_o, rs2_o, shamt_o;
    logic [2:0]  funct3_o;
    logic        pcsel_o, immsel_o, regwren_o, rs1sel_o, rs2sel_o, memren_o, memwren_o, brtaken_o;
    logic [1:0]  wbsel_o;
    logic [3:0]  alusel_o;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    rv32i_decode_exec_unit dut (
        .clk(clk), .rst(rst), .insn_i(insn_i), .pc_i(pc_i),
        .rs1data_i(rs1data_i), .rs2data_i(rs2data_i), .pc_o(pc_o), .insn_o(insn_o),
        .opcode_o(opcode_o), .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
        .funct3_o(funct3_o), .funct7_o(funct7_o), .shamt_o(shamt_o), .imm_o(imm_o),
        .pcsel_o(pcsel_o), .immsel_o(immsel_o), .regwren_o(regwren_o), .rs1sel_o(rs1sel_o),
        .rs2sel_o(rs2sel_o), .memren_o(memren_o), .memwren_o(memwren_o), .wbsel_o(wbsel_o),
        .alusel_o(alusel_o), .res_o(res_o), .brtaken_o(brtaken_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Control word: pcsel immsel regwren rs1sel rs2sel memren memwren wbsel[2] alusel[4] brtaken
    task automatic check_ctl(input string tag, input logic [13:0] exp);
        check(tag, {18'h0, pcsel_o, immsel_o, regwren_o, rs1sel_o, rs2sel_o, memren_o,
                    memwren_o, wbsel_o, alusel_o, brtaken_o}, {18'h0, exp});
    endtask

    task automatic apply(input logic [31:0] insn, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2);
        @(posedge clk);
        insn_i = insn; pc_i = pc; rs1data_i = r1; rs2data_i = r2;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        apply(32'h0, 32'h0, 32'h1234, 32'h5678);
        check("reset_res", res_o, 32'h0);
        check_ctl("reset_ctl", {7'b0, 2'd0, 4'd0, 1'b0});
        rst = 1'b1;

        apply(32'hFFB00093, 32'h01000000, 32'h0, 32'h0);
        check("addi_imm", imm_o, 32'hFFFFFFFB);
        check("addi_res", res_o, 32'hFFFFFFFB);
        check_ctl("addi_ctl", {7'b0110100, 2'd0, 4'd0, 1'b0});
        check("addi_fields", {opcode_o, rd_o, rs1_o, funct3_o}, {7'h13, 5'd1, 5'd0, 3'd0});
        check("addi_pc", pc_o, 32'h01000000);
        check("addi_insn", insn_o, 32'hFFB00093);

        apply(32'h402081B3, 32'h0, 32'd5, 32'd7);
        check("sub_res", res_o, 32'hFFFFFFFE);
        check_ctl("sub_ctl", {7'b0010000, 2'd0, 4'd1, 1'b0});
        check("sub_fields", {funct7_o, rd_o, rs1_o, rs2_o}, {7'h20, 5'd3, 5'd1, 5'd2});

        apply(32'h4020D1B3, 32'h0, 32'h80000000, 32'd4);
        check("sra_res", res_o, 32'hF8000000);
        check("sra_alusel", {28'h0, alusel_o}, 32'd7);
        apply(32'h0020D1B3, 32'h0, 32'h80000000, 32'd4);
        check("srl_res", res_o, 32'h08000000);
        apply(32'h4040D193, 32'h0, 32'h80000000, 32'd99);
        check("srai_res", res_o, 32'hF8000000);
        check("srai_shamt", {27'h0, shamt_o}, 32'd4);

        apply(32'h00208463, 32'h01000010, 32'd3, 32'd3);
        check("beq_res", res_o, 32'h01000018);
        check("beq_imm", imm_o, 32'h8);
        check_ctl("beq_ctl", {7'b1101100, 2'd0, 4'd0, 1'b1});
        rst = 1'b0;
        #1 check("beq_rst_res", res_o, 32'h01000018);
        rst = 1'b1;
        apply(32'h00208463, 32'h01000010, 32'd3, 32'd4);
        check("beq_nt", {31'h0, brtaken_o}, 32'd0);
        apply(32'h0020C463, 32'h01000010, 32'hFFFFFFFF, 32'd1);
        check("blt_t", {31'h0, brtaken_o}, 32'd1);
        apply(32'h0020E463, 32'h01000010, 32'hFFFFFFFF, 32'd1);
        check("bltu_nt", {31'h0, brtaken_o}, 32'd0);
        apply(32'h0020A463, 32'h01000010, 32'd3, 32'd3);
        check("bf3_2_nt", {31'h0, brtaken_o}, 32'd0);

        apply(32'h004280E7, 32'h01000000, 32'h01000103, 32'h0);
        check("jalr_res", res_o, 32'h01000106);
        check_ctl("jalr_ctl", {7'b1010100, 2'd2, 4'd0, 1'b1});
        apply(32'h010000EF, 32'h01000000, 32'h0, 32'h0);
        check("jal_imm", imm_o, 32'h10);
        check("jal_res", res_o, 32'h01000010);
        check_ctl("jal_ctl", {7'b1011100, 2'd2, 4'd0, 1'b1});

        apply(32'h0020A423, 32'h0, 32'h01000100, 32'h55);
        check("sw_imm", imm_o, 32'h8);
        check("sw_res", res_o, 32'h01000108);
        check_ctl("sw_ctl", {7'b0100101, 2'd0, 4'd0, 1'b0});
        apply(32'h0080A103, 32'h0, 32'h01000100, 32'h55);
        check("lw_res", res_o, 32'h01000108);
        check_ctl("lw_ctl", {7'b0110110, 2'd1, 4'd0, 1'b0});

        apply(32'h12345137, 32'h01000000, 32'hAAAA, 32'hBBBB);
        check("lui_imm", imm_o, 32'h12345000);
        check("lui_res", res_o, 32'h12345000);
        check_ctl("lui_ctl", {7'b0110000, 2'd3, 4'd10, 1'b0});
        apply(32'h12345117, 32'h01000000, 32'hAAAA, 32'hBBBB);
        check("auipc_res", res_o, 32'h13345000);
        check_ctl("auipc_ctl", {7'b0011100, 2'd0, 4'd0, 1'b0});

        apply(32'h00000000, 32'h01000000, 32'h1111, 32'h2222);
        check("zero_res", res_o, 32'h0);
        check("zero_imm", imm_o, 32'h0);
        check_ctl("zero_ctl", {7'b0, 2'd0, 4'd0, 1'b0});
        apply(32'h00000073, 32'h01000000, 32'h1111, 32'h2222);
        check("sys_res", res_o, 32'h0);
        check_ctl("sys_ctl", {7'b0, 2'd0, 4'd0, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
